// File: rtl/cpu_pkg.sv
// Shared CPU constants for the data RAM path.
// Address/data widths and w_mem encodings of the ram16x8 instance.
package cpu_pkg;

    localparam int   RAM_AW      = 4;
    localparam int   RAM_DW      = 8;
    localparam logic W_MEM_READ  = 1'b0;
    localparam logic W_MEM_WRITE = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req_i starting at ptr_i and wrapping mod N.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          any_o
);

    int idx;

    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port 16x8 data RAM between NUM_REQ requesters.
// Round-robin grant with a bounded lock for bursts; read data one cycle after grant.
module ram_port_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*RAM_AW-1:0] addr,
    input  logic [NUM_REQ*RAM_DW-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [RAM_DW-1:0]         rdata,
    output logic [RAM_AW-1:0]         ram_addr,
    output logic [RAM_DW-1:0]         ram_data_in,
    output logic                      ram_w_mem,
    input  logic [RAM_DW-1:0]         ram_data_out
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic               owner_vld_q, owner_vld_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic               rr_any;
    logic [NUM_REQ-1:0] owner_oh;
    logic               others;
    logic               lock_win;
    logic               any_g;
    logic [PW-1:0]      win;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .any_o (rr_any)
    );

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    assign others   = |(req & ~owner_oh);
    assign lock_win = owner_vld_q & req[owner_q] & lock[owner_q]
                    & ((hold_q < HOLD_MAX) | ~others);

    // Reset low forces an idle bus so the RAM can never be written.
    always_comb begin
        gnt   = '0;
        any_g = 1'b0;
        if (reset) begin
            gnt   = lock_win ? owner_oh : rr_gnt;
            any_g = lock_win | rr_any;
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) win = PW'(i);
        end
    end

    always_comb begin
        ram_addr    = '0;
        ram_data_in = '0;
        ram_w_mem   = W_MEM_READ;
        if (any_g) begin
            ram_addr    = addr[int'(win)*RAM_AW +: RAM_AW];
            ram_data_in = wdata[int'(win)*RAM_DW +: RAM_DW];
            ram_w_mem   = we[win] ? W_MEM_WRITE : W_MEM_READ;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = 1'b0;
        hold_d      = '0;
        rvalid_d    = '0;
        if (any_g) begin
            ptr_d       = PW'((int'(win) + 1) % NUM_REQ);
            owner_d     = win;
            owner_vld_d = 1'b1;
            if (owner_vld_q && win == owner_q)
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
            else
                hold_d = HW'(1);
            rvalid_d = we[win] ? '0 : gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            hold_q      <= '0;
            rvalid_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            hold_q      <= hold_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = ram_data_out;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: 2-port instance with a RAM model,
// plus a 3-port instance for wrap-around and idle behaviour.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 2-requester instance
    logic       rst_a;
    logic [1:0] req_a, we_a, lock_a, gnt_a, rv_a;
    logic [7:0] addr_a;
    logic [15:0] wd_a;
    logic [7:0] rdata_a, din_a, dout_a;
    logic [3:0] raddr_a;
    logic       wmem_a;

    // 3-requester instance
    logic       rst_b;
    logic [2:0] req_b, we_b, lock_b, gnt_b, rv_b;
    logic [11:0] addr_b;
    logic [23:0] wd_b;
    logic [7:0] rdata_b, din_b;
    logic [3:0] raddr_b;
    logic       wmem_b;

    logic [7:0] mem_a [16];

    ram_port_arbiter #(.NUM_REQ(2), .MAX_HOLD(4)) dut_a (
        .clk          (clk),
        .reset        (rst_a),
        .req          (req_a),
        .we           (we_a),
        .lock         (lock_a),
        .addr         (addr_a),
        .wdata        (wd_a),
        .gnt          (gnt_a),
        .rvalid       (rv_a),
        .rdata        (rdata_a),
        .ram_addr     (raddr_a),
        .ram_data_in  (din_a),
        .ram_w_mem    (wmem_a),
        .ram_data_out (dout_a)
    );

    ram_port_arbiter #(.NUM_REQ(3), .MAX_HOLD(4)) dut_b (
        .clk          (clk),
        .reset        (rst_b),
        .req          (req_b),
        .we           (we_b),
        .lock         (lock_b),
        .addr         (addr_b),
        .wdata        (wd_b),
        .gnt          (gnt_b),
        .rvalid       (rv_b),
        .rdata        (rdata_b),
        .ram_addr     (raddr_b),
        .ram_data_in  (din_b),
        .ram_w_mem    (wmem_b),
        .ram_data_out (8'h00)
    );

    // ram16x8 model: registered read
    always @(posedge clk) begin
        if (wmem_a) mem_a[raddr_a] <= din_a;
        else        dout_a <= mem_a[raddr_a];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    logic [1:0] exp3 [4];
    logic [1:0] exp4 [6];

    initial begin
        exp3[0] = 2'b01; exp3[1] = 2'b10; exp3[2] = 2'b01; exp3[3] = 2'b10;
        exp4[0] = 2'b01; exp4[1] = 2'b01; exp4[2] = 2'b01;
        exp4[3] = 2'b01; exp4[4] = 2'b10; exp4[5] = 2'b01;

        rst_a = 1'b0; req_a = 2'b11; we_a = 2'b11; lock_a = 2'b00;
        addr_a = {4'd15, 4'd2}; wd_a = {8'hA5, 8'h3C};
        rst_b = 1'b0; req_b = '0; we_b = '0; lock_b = '0;
        addr_b = '0; wd_b = '0;
        cyc();

        // 1: reset holds bus idle
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("rst_gnt", gnt_a, 0);
            chk("rst_wmem", wmem_a, 0);
            chk("rst_addr", raddr_a, 0);
            chk("rst_rvalid", rv_a, 0);
            cyc();
        end
        rst_a = 1'b1; we_a = 2'b00;
        at_neg();
        chk("first_gnt", gnt_a, 2'b01);
        chk("first_addr", raddr_a, 4'd2);
        cyc();
        req_a = 2'b00;
        at_neg();
        chk("first_rvalid", rv_a, 2'b01);
        chk("idle_gnt", gnt_a, 0);
        cyc();

        // 2: write then read-back by req1
        req_a = 2'b10; we_a = 2'b10;
        at_neg();
        chk("wr_gnt", gnt_a, 2'b10);
        chk("wr_wmem", wmem_a, 1);
        chk("wr_addr", raddr_a, 4'd15);
        chk("wr_din", din_a, 8'hA5);
        cyc();
        we_a = 2'b00;
        at_neg();
        chk("rd_gnt", gnt_a, 2'b10);
        chk("rd_wmem", wmem_a, 0);
        chk("wr_no_rvalid", rv_a, 0);
        cyc();
        req_a = 2'b00;
        at_neg();
        chk("rd_rvalid", rv_a, 2'b10);
        chk("rd_rdata", rdata_a, 8'hA5);
        cyc();

        // 3: alternating reads without lock
        req_a = 2'b11; we_a = 2'b00;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("alt_gnt", gnt_a, exp3[i]);
            chk("alt_rvalid", rv_a, (i == 0) ? 2'b00 : exp3[i-1]);
            if (i > 0 && exp3[i-1] == 2'b10)
                chk("alt_rdata", rdata_a, 8'hA5);
            cyc();
        end
        req_a = 2'b00;
        at_neg();
        chk("alt_rvalid_last", rv_a, 2'b10);
        cyc();

        // 4: bounded lock, then lock alone, then saturation hand-off
        req_a = 2'b11; lock_a = 2'b01;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            chk("hold_gnt", gnt_a, exp4[i]);
            cyc();
        end
        req_a = 2'b01;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            chk("solo_gnt", gnt_a, 2'b01);
            cyc();
        end
        req_a = 2'b11;
        at_neg();
        chk("sat_handoff", gnt_a, 2'b10);
        cyc();
        req_a = 2'b00; lock_a = 2'b00;
        cyc();

        // 5: reset right after a granted read
        req_a = 2'b01;
        at_neg();
        chk("r5_gnt", gnt_a, 2'b01);
        cyc();
        rst_a = 1'b0;
        at_neg();
        chk("r5_rst_gnt", gnt_a, 0);
        chk("r5_rvalid_n1", rv_a, 2'b01);
        cyc();
        rst_a = 1'b1; req_a = 2'b11;
        at_neg();
        chk("r5_rvalid_n2", rv_a, 0);
        chk("r5_ptr0", gnt_a, 2'b01);
        cyc();
        req_a = 2'b00;
        cyc();

        // 6: three requesters, wrap and idle
        rst_b = 1'b1; req_b = 3'b010;
        at_neg();
        chk("b_gnt1", gnt_b, 3'b010);
        cyc();
        req_b = 3'b101;
        at_neg();
        chk("b_gnt2", gnt_b, 3'b100);
        cyc();
        at_neg();
        chk("b_wrap", gnt_b, 3'b001);
        cyc();
        req_b = 3'b000;
        at_neg();
        chk("b_idle", gnt_b, 3'b000);
        cyc();
        req_b = 3'b101; lock_b = 3'b001;
        at_neg();
        chk("b_owner_clr", gnt_b, 3'b100);
        cyc();
        req_b = '0; lock_b = '0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
